// File: rtl/range_arbiter.sv
// range_arbiter: round-robin sharing of one range-finder engine between sample-stream requesters
module range_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 2,
  parameter int MAX_LEN = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_done,
  output logic [WIDTH-1:0]      resp_range,
  output logic                  resp_error,
  output logic                  eng_go,
  output logic                  eng_finish,
  output logic [WIDTH-1:0]      eng_data,
  input  logic [WIDTH-1:0]      eng_range,
  input  logic                  eng_error,
  output logic                  busy
);
  localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  logic [1:0]       state;
  logic [GW-1:0]    grant, rr_ptr, pick, nxt;
  logic [CW-1:0]    cnt;
  logic             started;
  logic [WIDTH-1:0] last_q, g_data;
  logic [NREQ-1:0]  sel;
  logic             g_valid, g_last, in_busy, in_fin, accept, at_max;
  always_comb begin
    pick = '0;
    for (int j = NREQ - 1; j >= 0; j--) if (req_valid[j]) pick = GW'(j);
    for (int j = NREQ - 1; j >= 0; j--) if (req_valid[j] && GW'(j) >= rr_ptr) pick = GW'(j);
  end
  always_comb begin
    sel     = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int j = 0; j < NREQ; j++) begin
      sel[j] = GW'(j) == grant;
      if (GW'(j) == grant) begin
        g_valid = req_valid[j];
        g_last  = req_last[j];
        g_data  = req_data[j*WIDTH +: WIDTH];
      end
    end
  end
  assign in_busy    = state == BUSY;
  assign in_fin     = state == FIN;
  assign busy       = state != IDLE;
  assign accept     = in_busy & g_valid;
  assign at_max     = cnt + 1'b1 == CW'(MAX_LEN);
  assign nxt        = grant == GW'(NREQ - 1) ? '0 : grant + 1'b1;
  assign req_ready  = in_busy ? sel : '0;
  assign eng_go     = in_busy & (accept | started);
  assign eng_finish = in_fin;
  assign eng_data   = accept ? g_data : ((in_busy & started) | in_fin) ? last_q : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      started    <= 1'b0;
      last_q     <= '0;
      resp_done  <= '0;
      resp_range <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_done <= '0;
      if (state == IDLE) begin
        if (|req_valid) begin
          grant   <= pick;
          state   <= BUSY;
          cnt     <= '0;
          started <= 1'b0;
        end
      end else if (eng_error) begin
        resp_done  <= sel;
        resp_error <= 1'b1;
        resp_range <= '0;
        rr_ptr     <= nxt;
        state      <= IDLE;
      end else if (in_fin) begin
        resp_done  <= sel;
        resp_error <= 1'b0;
        resp_range <= eng_range;
        rr_ptr     <= nxt;
        state      <= IDLE;
      end else if (accept) begin
        started <= 1'b1;
        last_q  <= g_data;
        cnt     <= cnt + 1'b1;
        state   <= (g_last || at_max) ? FIN : BUSY;
      end
    end
  end
endmodule

// File: doc/range_arbiter.md
Name: range_arbiter

Overview:
- Shares one range-finder engine between NREQ sample-stream requesters.
- Grants the engine to one requester for a whole sequence, using round-robin order.
- Generates the engine's go/finish/data sequencing, fills input bubbles, captures the range result and returns it to the granted requester.
- Sits between the requesters and the range-finder engine in the top-level datapath.

Parameters:
- WIDTH, 8, sample and range width in bits.
- NREQ, 2, number of requesters (2..8).
- MAX_LEN, 255, maximum accepted samples per session before a forced finish.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  NREQ  requester i has a sample on its data slice.
- req_data  input  NREQ*WIDTH  sample for requester i, in bits [i*WIDTH +: WIDTH].
- req_last  input  NREQ  marks requester i's current sample as the final sample of its sequence.
- req_ready  output  NREQ  a sample is accepted when req_valid[i] & req_ready[i].
- resp_done  output  NREQ  one-cycle pulse to the requester that owned the session.
- resp_range  output  WIDTH  result; stable from the resp_done pulse until the next resp_done.
- resp_error  output  1  qualifies resp_done; 1 means the session was aborted.
- eng_go  output  1  go to the engine.
- eng_finish  output  1  finish to the engine.
- eng_data  output  WIDTH  data_in to the engine.
- eng_range  input  WIDTH  engine range; combinationally valid during the finish cycle.
- eng_error  input  1  engine debug_error.
- busy  output  1  a session is in progress (state is not IDLE).

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0. req_ready, resp_done, resp_range, resp_error, eng_* and busy are all 0. Reset mid-session abandons the session with no resp_done pulse.
- IDLE: if any req_valid is set, grant goes to the first set bit at or after rr_ptr (wrapping modulo NREQ), registered; state goes to BUSY. No sample is accepted in IDLE.
- BUSY:
  - req_ready[grant]=1; all other ready bits are 0.
  - The first accepted sample drives eng_go=1, eng_data=sample, and sets `started`, which stays set for the session.
  - Each later accepted sample drives eng_go=1, eng_data=sample.
  - Bubble cycle (started, no valid): eng_go=1, eng_data=last accepted sample, held in a register. Repeating a sample cannot change min or max.
  - Before `started`: eng_go=0, eng_data=0.
  - An accepted sample with req_last=1 goes to FIN.
  - When the accepted-sample counter reaches MAX_LEN, the transition to FIN is forced even if req_last=0.
- FIN (one cycle):
  - Drives eng_finish=1, eng_go=0, eng_data=last sample; req_ready=0.
  - At the clock edge, resp_range<=eng_range, resp_error<=0, resp_done[grant]<=1, rr_ptr<=(grant+1)%NREQ; state goes to IDLE.
  - A single-sample sequence (first sample has last=1) therefore finishes on the following cycle, and the engine never sees go and finish together.
- Latency: resp_done pulses 2 cycles after the last sample is accepted (FIN cycle, then the registered pulse).
- Error abort:
  - eng_error=1 in BUSY or FIN drives resp_done[grant]=1, resp_error=1 and resp_range=0 on the next edge.
  - rr_ptr advances and state goes to IDLE.
  - The engine recovers on the next session's go.
- resp_done is a single-cycle pulse with at most one bit set.
- IDLE evaluates new requests in the same cycle resp_done is high. There are no back-to-back grants without an IDLE cycle.
- The sample counter is WIDTH-independent, clog2(MAX_LEN+1) bits, and is cleared on entering BUSY.
- Requesters that are not granted are ignored entirely. Their req_last and req_data have no effect.
- If req_valid[grant] drops before `started`, state stays in BUSY indefinitely. There is no timeout.

Test Plan:
- Single requester 0 streams 10,50,3,20(last) with no bubbles -> eng_go high for 4 cycles, then eng_finish 1 cycle, then resp_done[0]=1, resp_range=47, resp_error=0.
- Requester 1 sends one sample 77 with last=1 -> eng_go 1 cycle, eng_finish the next cycle with eng_data=77, then resp_done[1]=1, resp_range=0.
- Both requesters valid continuously, 3-sample sequences each -> grants alternate 0,1,0,1 and each resp_done returns to the correct requester.
- Requester 0 sends 5, two bubble cycles, then 9(last) -> eng_data reads 5,5,5,9 with eng_go steady at 1, and resp_range=4.
- Engine eng_error forced high mid-session -> next cycle resp_done pulses with resp_error=1 and resp_range=0; the next session completes normally.
- rst_n asserted low mid-session, then released -> all outputs 0 and no resp_done pulse; a new session from requester 0 is granted first (rr_ptr=0).
